// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Opcodes shared with the EX stage.
  localparam logic [5:0] OP_LW = 6'b001100;
  localparam logic [5:0] OP_SW = 6'b001101;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  rd_add;
    logic [31:0] data;
  } mem_wb_t;

  // Word accesses must have the two byte-offset bits clear.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues word loads/stores over a req/ack handshake,
// stalls EX while an access is outstanding and registers the MEM->WB bundle.
//
// state | meaning
// IDLE  | sample the EX bundle; ALU ops and error cases retire next cycle
// WAIT  | memory access outstanding; EX stalled until ack or timeout
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_2_mem,
  input  logic [31:0]       rd,
  input  logic [31:0]       A,
  input  logic [31:0]       store_data_2_mem,
  input  logic              mem_read_2_mem,
  input  logic              mem_write_2_mem,
  input  logic              mem_to_reg_2_mem,
  input  logic [4:0]        rd_add_value_2_mem,
  output logic              stall_2_ex,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd_add,
  output logic [31:0]       wb_data,
  output logic              err_align,
  output logic              err_timeout,
  output logic              err_proto
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_add_q, rd_add_d;
  logic              m2r_q, m2r_d;
  logic [31:0]       alu_q, alu_d;
  mem_wb_t           wb_q, wb_d;
  logic              err_align_q, err_align_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_proto_q, err_proto_d;

  logic in_wait;
  logic both_rw;
  logic one_rw;
  logic start_acc;
  logic wait_live;

  assign in_wait   = (state_q == WAIT);
  assign both_rw   = mem_read_2_mem & mem_write_2_mem;
  assign one_rw    = mem_read_2_mem ^ mem_write_2_mem;
  assign start_acc = !in_wait && valid_2_mem && one_rw && word_aligned(A[1:0]);
  // Request stays up in WAIT until ack arrives or the timeout cycle is reached.
  assign wait_live = in_wait && !dmem_ack && (cnt_q != CNT_LAST);

  // Memory-side outputs: driven from inputs in the request cycle, from the
  // latched copy while waiting; forced low while reset is asserted.
  assign dmem_req   = !reset && (start_acc || wait_live);
  assign stall_2_ex = !reset && in_wait && !dmem_ack;
  assign dmem_we    = reset ? 1'b0 :
                      in_wait ? we_q : (start_acc ? mem_write_2_mem : 1'b0);
  assign dmem_addr  = reset ? '0 :
                      in_wait ? addr_q : (start_acc ? A[ADDR_W-1:0] : '0);
  assign dmem_wdata = reset ? '0 :
                      in_wait ? wdata_q : (start_acc ? store_data_2_mem : '0);

  assign wb_valid    = wb_q.valid;
  assign wb_we       = wb_q.we;
  assign wb_rd_add   = wb_q.rd_add;
  assign wb_data     = wb_q.data;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;

  // Next-state, latched access, WB bundle and sticky error computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_add_d      = rd_add_q;
    m2r_d         = m2r_q;
    alu_d         = alu_q;
    wb_d          = '0;
    err_align_d   = err_align_q;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q;

    case (state_q)
      IDLE: begin
        if (valid_2_mem) begin
          if (both_rw) begin
            err_proto_d   = 1'b1;
            wb_d.valid    = 1'b1;
            wb_d.rd_add   = rd_add_value_2_mem;
          end else if (one_rw) begin
            if (word_aligned(A[1:0])) begin
              state_d  = WAIT;
              cnt_d    = '0;
              we_d     = mem_write_2_mem;
              addr_d   = A[ADDR_W-1:0];
              wdata_d  = store_data_2_mem;
              rd_add_d = rd_add_value_2_mem;
              m2r_d    = mem_to_reg_2_mem;
              alu_d    = rd;
            end else begin
              err_align_d = 1'b1;
              wb_d.valid  = 1'b1;
              wb_d.rd_add = rd_add_value_2_mem;
            end
          end else begin
            wb_d.valid  = 1'b1;
            wb_d.we     = (rd_add_value_2_mem != 5'd0);
            wb_d.rd_add = rd_add_value_2_mem;
            wb_d.data   = rd;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          state_d     = IDLE;
          wb_d.valid  = 1'b1;
          wb_d.rd_add = rd_add_q;
          if (!we_q) begin
            wb_d.we   = (rd_add_q != 5'd0);
            wb_d.data = m2r_q ? dmem_rdata : alu_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
          wb_d.valid    = 1'b1;
          wb_d.rd_add   = rd_add_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register FSM state, timeout counter, latched access and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_add_q      <= '0;
      m2r_q         <= 1'b0;
      alu_q         <= '0;
      wb_q          <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_add_q      <= rd_add_d;
      m2r_q         <= m2r_d;
      alu_q         <= alu_d;
      wb_q          <= wb_d;
      err_align_q   <= err_align_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_2_mem;
  logic [31:0] rd;
  logic [31:0] A;
  logic [31:0] store_data_2_mem;
  logic        mem_read_2_mem;
  logic        mem_write_2_mem;
  logic        mem_to_reg_2_mem;
  logic [4:0]  rd_add_value_2_mem;
  logic        stall_2_ex;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd_add;
  logic [31:0] wb_data;
  logic        err_align;
  logic        err_timeout;
  logic        err_proto;

  mem_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .valid_2_mem        (valid_2_mem),
    .rd                 (rd),
    .A                  (A),
    .store_data_2_mem   (store_data_2_mem),
    .mem_read_2_mem     (mem_read_2_mem),
    .mem_write_2_mem    (mem_write_2_mem),
    .mem_to_reg_2_mem   (mem_to_reg_2_mem),
    .rd_add_value_2_mem (rd_add_value_2_mem),
    .stall_2_ex         (stall_2_ex),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .wb_valid           (wb_valid),
    .wb_we              (wb_we),
    .wb_rd_add          (wb_rd_add),
    .wb_data            (wb_data),
    .err_align          (err_align),
    .err_timeout        (err_timeout),
    .err_proto          (err_proto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access with its age counted from the
  // request cycle; the request may be up for at most TIMEOUT cycles.
  bit          m_busy = 1'b0;
  int          m_age = 0;
  bit          m_write;
  logic [31:0] m_addr, m_wdata, m_alu;
  logic [4:0]  m_reg;
  bit          m_m2r;
  bit          e_wb_valid = 1'b0, e_wb_we = 1'b0, e_rd_care = 1'b0, e_data_care = 1'b0;
  logic [4:0]  e_wb_rd = '0;
  logic [31:0] e_wb_data = '0;
  bit          e_align = 1'b0, e_to = 1'b0, e_proto = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_age = 0;
      e_wb_valid = 1'b0; e_wb_we = 1'b0; e_rd_care = 1'b0; e_data_care = 1'b0;
      e_wb_rd = '0; e_wb_data = '0;
      e_align = 1'b0; e_to = 1'b0; e_proto = 1'b0;
    end else begin
      e_wb_valid = 1'b0; e_wb_we = 1'b0; e_rd_care = 1'b0; e_data_care = 1'b0;
      e_wb_rd = '0; e_wb_data = '0;
      if (!m_busy) begin
        if (valid_2_mem) begin
          if (mem_read_2_mem && mem_write_2_mem) begin
            e_proto = 1'b1; e_wb_valid = 1'b1;
          end else if (mem_read_2_mem || mem_write_2_mem) begin
            if (A[1:0] != 2'b00) begin
              e_align = 1'b1; e_wb_valid = 1'b1;
            end else begin
              m_busy = 1'b1; m_age = 1;
              m_write = mem_write_2_mem; m_addr = A; m_wdata = store_data_2_mem;
              m_reg = rd_add_value_2_mem; m_m2r = mem_to_reg_2_mem; m_alu = rd;
            end
          end else begin
            e_wb_valid = 1'b1; e_wb_we = (rd_add_value_2_mem != 0);
            e_wb_rd = rd_add_value_2_mem; e_wb_data = rd;
            e_rd_care = 1'b1; e_data_care = 1'b1;
          end
        end
      end else if (dmem_ack) begin
        m_busy = 1'b0; e_wb_valid = 1'b1; e_wb_rd = m_reg;
        e_rd_care = 1'b1; e_data_care = 1'b1;
        if (m_write) begin
          e_wb_we = 1'b0; e_wb_data = '0;
        end else begin
          e_wb_we = (m_reg != 0);
          e_wb_data = m_m2r ? dmem_rdata : m_alu;
        end
      end else if (m_age >= TIMEOUT) begin
        m_busy = 1'b0; e_to = 1'b1; e_wb_valid = 1'b1; e_wb_we = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  logic exp_req, exp_stall;

  always @(negedge clk) begin
    if (run) begin
      if (reset) begin
        exp_req = 1'b0; exp_stall = 1'b0;
      end else if (!m_busy) begin
        exp_stall = 1'b0;
        exp_req = valid_2_mem && (mem_read_2_mem ^ mem_write_2_mem) && (A[1:0] == 2'b00);
      end else begin
        exp_stall = !dmem_ack;
        exp_req = !dmem_ack && (m_age < TIMEOUT);
      end
      chk("cmp_stall", stall_2_ex, exp_stall);
      chk("cmp_req", dmem_req, exp_req);
      if (exp_req) begin
        chk("cmp_we", dmem_we, m_busy ? m_write : mem_write_2_mem);
        chk("cmp_addr", dmem_addr, m_busy ? m_addr : A);
        if (m_busy ? m_write : mem_write_2_mem)
          chk("cmp_wdata", dmem_wdata, m_busy ? m_wdata : store_data_2_mem);
      end
      chk("cmp_wb_valid", wb_valid, e_wb_valid);
      if (reset || e_wb_valid) chk("cmp_wb_we", wb_we, e_wb_we);
      if (reset || e_rd_care) chk("cmp_wb_rd", wb_rd_add, e_wb_rd);
      if (reset || e_data_care) chk("cmp_wb_data", wb_data, e_wb_data);
      chk("cmp_err_align", err_align, e_align);
      chk("cmp_err_timeout", err_timeout, e_to);
      chk("cmp_err_proto", err_proto, e_proto);
      if (dmem_req) req_cycles++;
    end
  end

  task automatic drive(input logic v, input logic r, input logic w, input logic m2r,
                       input logic [31:0] rd_v, input logic [31:0] a_v, input logic [31:0] sd_v,
                       input logic [4:0] ra, input logic ack, input logic [31:0] rdata);
    valid_2_mem = v; mem_read_2_mem = r; mem_write_2_mem = w; mem_to_reg_2_mem = m2r;
    rd = rd_v; A = a_v; store_data_2_mem = sd_v; rd_add_value_2_mem = ra;
    dmem_ack = ack; dmem_rdata = rdata;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall_2_ex, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_errs", {err_align, err_timeout, err_proto}, 0);
    reset = 1'b0;
    run = 1'b1;
    step();

    // ALU op retires in one cycle without stalling
    drive(1, 0, 0, 0, 32'h0000_0007, 32'h0, 32'h0, 5'd5, 0, 32'h0);
    #1 chk("t1_stall", stall_2_ex, 0);
    step();
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_we", wb_we, 1);
    chk("t1_wb_data", wb_data, 32'h7);
    chk("t1_wb_rd", wb_rd_add, 5);
    idle();
    step();
    chk("t1_wb_drop", wb_valid, 0);

    // load, ack in the third wait cycle
    req_cycles = 0;
    drive(1, 1, 0, 1, 32'h55, 32'h100, 32'h0, 5'd3, 0, 32'h0);
    #1 chk("t2_req0", dmem_req, 1);
    chk("t2_addr0", dmem_addr, 32'h100);
    chk("t2_we0", dmem_we, 0);
    step();
    step();
    #1 chk("t2_stall", stall_2_ex, 1);
    chk("t2_addr_hold", dmem_addr, 32'h100);
    step();
    drive(1, 1, 0, 1, 32'h55, 32'h100, 32'h0, 5'd3, 1, 32'hDEAD_BEEF);
    #1 chk("t2_req_ack", dmem_req, 0);
    chk("t2_stall_ack", stall_2_ex, 0);
    step();
    chk("t2_wb_valid", wb_valid, 1);
    chk("t2_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("t2_wb_we", wb_we, 1);
    chk("t2_wb_rd", wb_rd_add, 3);
    chk("t2_req_cycles", req_cycles, 3);
    idle();
    step();

    // store, immediate ack
    drive(1, 0, 1, 0, 32'h0, 32'h104, 32'h1234_5678, 5'd0, 0, 32'h0);
    #1 chk("t3_req", dmem_req, 1);
    chk("t3_we", dmem_we, 1);
    chk("t3_wdata", dmem_wdata, 32'h1234_5678);
    step();
    drive(1, 0, 1, 0, 32'h0, 32'h104, 32'h1234_5678, 5'd0, 1, 32'h0);
    step();
    chk("t3_wb_valid", wb_valid, 1);
    chk("t3_wb_we", wb_we, 0);
    chk("t3_wb_data", wb_data, 32'h0);
    idle();
    step();

    // misaligned load
    drive(1, 1, 0, 1, 32'h0, 32'h102, 32'h0, 5'd4, 0, 32'h0);
    #1 chk("t4_req", dmem_req, 0);
    step();
    chk("t4_wb_valid", wb_valid, 1);
    chk("t4_wb_we", wb_we, 0);
    chk("t4_err_align", err_align, 1);
    idle();
    step();

    // read and write together
    drive(1, 1, 1, 0, 32'h0, 32'h108, 32'h0, 5'd6, 0, 32'h0);
    #1 chk("tp_req", dmem_req, 0);
    step();
    chk("tp_wb_valid", wb_valid, 1);
    chk("tp_wb_we", wb_we, 0);
    chk("tp_err_proto", err_proto, 1);
    idle();
    step();

    // stray ack in IDLE
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'hFFFF_FFFF);
    step();
    chk("tack_wb_valid", wb_valid, 0);

    // back-to-back loads: ALU-sourced write-back, then load to r0
    drive(1, 1, 0, 0, 32'hCAFE_0001, 32'h110, 32'h0, 5'd7, 0, 32'h0);
    step();
    drive(1, 1, 0, 0, 32'hCAFE_0001, 32'h110, 32'h0, 5'd7, 1, 32'h1111_2222);
    step();
    chk("tb_wb_data0", wb_data, 32'hCAFE_0001);
    chk("tb_wb_we0", wb_we, 1);
    drive(1, 1, 0, 1, 32'h0, 32'h114, 32'h0, 5'd0, 0, 32'h0);
    step();
    drive(1, 1, 0, 1, 32'h0, 32'h114, 32'h0, 5'd0, 1, 32'hAAAA_5555);
    step();
    chk("tb_wb_data1", wb_data, 32'hAAAA_5555);
    chk("tb_wb_we1", wb_we, 0);
    idle();
    step();

    // timeout
    req_cycles = 0;
    drive(1, 1, 0, 1, 32'h0, 32'h200, 32'h0, 5'd9, 0, 32'h0);
    repeat (4) step();
    #1 chk("t5_req_last", dmem_req, 0);
    chk("t5_stall_last", stall_2_ex, 1);
    step();
    chk("t5_wb_valid", wb_valid, 1);
    chk("t5_wb_we", wb_we, 0);
    chk("t5_err_timeout", err_timeout, 1);
    chk("t5_req_cycles", req_cycles, 4);
    idle();
    step();
    chk("t5_idle_stall", stall_2_ex, 0);

    // reset in the second wait cycle
    drive(1, 1, 0, 1, 32'h0, 32'h300, 32'h0, 5'd10, 0, 32'h0);
    step();
    step();
    reset = 1'b1;
    #1 chk("t6_req", dmem_req, 0);
    chk("t6_stall", stall_2_ex, 0);
    chk("t6_wb_valid", wb_valid, 0);
    chk("t6_wb_bundle", {wb_we, wb_rd_add, wb_data}, 0);
    chk("t6_errs", {err_align, err_timeout, err_proto}, 0);
    idle();
    step();
    step();
    reset = 1'b0;
    step();
    drive(1, 0, 0, 0, 32'h0000_0042, 32'h0, 32'h0, 5'd12, 0, 32'h0);
    step();
    chk("t6_wb_valid", wb_valid, 1);
    chk("t6_wb_data", wb_data, 32'h42);
    chk("t6_wb_rd", wb_rd_add, 12);
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
